branch_target_predictor: RTL

Fetch-stage dynamic branch predictor. It combines a direct-mapped branch target buffer (BTB) with a table of 2-bit saturating pattern counters (PHT). For each fetch PC it produces the `branch_pred_t` that travels with the instruction down to the execute-stage prediction checker. It learns from the resolved outcome that execute sends back, and keeps a misprediction event counter.

---
 rtl/branch_target_predictor_pkg.sv | 10 +
 rtl/branch_target_predictor.sv | 88 ++++++++
 2 files changed

// File: rtl/branch_target_predictor_pkg.sv
// branch_target_predictor_pkg: PC, branch decision and prediction types shared by fetch and execute.
package branch_target_predictor_pkg;
  typedef logic [31:0] addrPC_t;
  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} branch_decision_t;
  typedef struct packed {
    logic             is_branch;
    branch_decision_t decision;
    addrPC_t          pred_addr;
  } branch_pred_t;
endpackage

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB plus 2-bit PHT with a misprediction counter.
// Optional gshare PHT indexing is enabled with BP_GSHARE_EN.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  addrPC_t          pc_fetch_i,
  output branch_pred_t     bpred_o,
  input  logic             upd_valid_i,
  input  addrPC_t          upd_pc_i,
  input  branch_decision_t upd_decision_i,
  input  addrPC_t          upd_target_i,
  input  logic             upd_mispred_i,
  input  logic             inv_i,
  output logic [31:0]      mispred_cnt_o
);
  localparam int N = 1 << IDX_W;
  logic             btb_valid_q [N];
  logic [TAG_W-1:0] btb_tag_q [N];
  addrPC_t          btb_tgt_q [N];
  logic [1:0]       pht_q [N];
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;
  logic [IDX_W-1:0] f_idx, f_pidx, u_idx, u_pidx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             f_hit, f_taken, u_hit, u_taken;
  logic [1:0]       pht_cur, pht_upd;
  logic             unused_ok;
  assign f_idx = pc_fetch_i[IDX_W+1:2];
  assign f_tag = pc_fetch_i[TAG_W+IDX_W+1:IDX_W+2];
  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];
  assign unused_ok = ^{pc_fetch_i, upd_pc_i};
`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  assign f_pidx = f_idx ^ ghr_q;
  assign u_pidx = u_idx ^ ghr_q;
  always_ff @(posedge clk_i)
    ghr_q <= rst_i ? '0 : upd_valid_i ? {ghr_q[IDX_W-2:0], upd_decision_i == TAKEN} : ghr_q;
`else
  assign f_pidx = f_idx;
  assign u_pidx = u_idx;
`endif
  // Lookup is masked during reset so tables never leak stale state to fetch.
  assign f_hit   = !rst_i && btb_valid_q[f_idx] && btb_tag_q[f_idx] == f_tag;
  assign f_taken = f_hit && pht_q[f_pidx][1];
  always_comb begin
    bpred_o           = '0;
    bpred_o.is_branch = f_hit;
    bpred_o.decision  = f_taken ? TAKEN : NOT_TAKEN;
    bpred_o.pred_addr = f_taken ? btb_tgt_q[f_idx] : pc_fetch_i + 32'd4;
  end
  assign u_hit   = btb_valid_q[u_idx] && btb_tag_q[u_idx] == u_tag;
  assign u_taken = upd_decision_i == TAKEN;
  assign pht_cur = pht_q[u_pidx];
  assign pht_upd = u_taken ? (pht_cur == 2'd3 ? 2'd3 : pht_cur + 2'd1)
                           : (pht_cur == 2'd0 ? 2'd0 : pht_cur - 2'd1);
  assign mispred_cnt_d = ((upd_valid_i || inv_i) && upd_mispred_i && mispred_cnt_q != '1)
                         ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        btb_valid_q[i] <= 1'b0;
        pht_q[i]       <= 2'd1;
      end
      mispred_cnt_q <= '0;
    end else begin
      mispred_cnt_q <= mispred_cnt_d;
      if (upd_valid_i) begin
        if (u_hit) begin
          pht_q[u_pidx] <= pht_upd;
          if (u_taken) btb_tgt_q[u_idx] <= upd_target_i;
        end else if (u_taken) begin
          btb_valid_q[u_idx] <= 1'b1;
          btb_tag_q[u_idx]   <= u_tag;
          btb_tgt_q[u_idx]   <= upd_target_i;
          pht_q[u_pidx]      <= 2'd2;
        end
      end else if (inv_i && u_hit) begin
        btb_valid_q[u_idx] <= 1'b0;
      end
    end
  end
endmodule
